// File: rtl/logic_and_erode_if.sv
// Pixel stream bundle for the 3x3 AND-erosion stage: raster input in, eroded pixels out.
interface logic_and_erode_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  frame_done;

  modport master (
    output data_valid, data_in,
    input  data_out, data_out_valid, frame_done
  );

  modport slave (
    input  data_valid, data_in,
    output data_out, data_out_valid, frame_done
  );
endinterface

// File: rtl/logic_and_erode.sv
// Streaming 3x3 erosion: bitwise AND of each complete neighbourhood, one output per interior pixel.
// Owns its two line buffers, raster counters and 3x3 window; output lags the completing accept by 1 clock.
module logic_and_erode #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LINE_WIDTH   = 317,
  parameter int unsigned FRAME_HEIGHT = 240
) (
  input logic              clock,
  input logic              rst_n,
  logic_and_erode_if.slave bus
);

  localparam int unsigned COL_W = $clog2(LINE_WIDTH);
  localparam int unsigned ROW_W = $clog2(FRAME_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Window column: [0] = row r-2, [1] = row r-1, [2] = row r
  typedef logic [2:0][DATA_WIDTH-1:0] column_t;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [DATA_WIDTH-1:0] r_lb1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb2 [LINE_WIDTH];
  column_t               r_win0, r_win1, r_win2;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_out_valid;
  logic                  r_frame_done;

  logic [DATA_WIDTH-1:0] w_lb1;
  logic [DATA_WIDTH-1:0] w_lb2;
  column_t               w_new_col;
  logic [DATA_WIDTH-1:0] w_and;
  logic                  w_emit;
  logic                  w_last;

  assign w_lb1     = r_lb1[r_col];
  assign w_lb2     = r_lb2[r_col];
  assign w_new_col = {bus.data_in, w_lb1, w_lb2};
  assign w_emit    = bus.data_valid && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_last    = bus.data_valid && (r_row == ROW_LAST) && (r_col == COL_LAST);

  // AND over the post-shift window: two surviving columns plus the incoming one
  always_comb begin
    w_and = '1;
    for (int i = 0; i < 3; i++) begin
      w_and = w_and & r_win1[i] & r_win2[i] & w_new_col[i];
    end
  end

  // Line buffers: read-before-write, the previous row cascades into LB2
  always_ff @(posedge clock) begin
    if (bus.data_valid) begin
      r_lb2[r_col] <= w_lb1;
      r_lb1[r_col] <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_col            <= '0;
      r_row            <= '0;
      r_win0           <= '1;
      r_win1           <= '1;
      r_win2           <= '1;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_data_out_valid <= w_emit;
      r_frame_done     <= w_last;
      if (w_emit) begin
        r_data_out <= w_and;
      end
      if (bus.data_valid) begin
        r_win0 <= r_win1;
        r_win1 <= r_win2;
        r_win2 <= w_new_col;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_data_out_valid;
  assign bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_logic_and_erode.sv
// Bench for logic_and_erode on a 5x4 frame: each output is compared with the AND of the
// 3x3 neighbourhood taken from an image array built from the pixels actually sent.
module tb_logic_and_erode;

  localparam int unsigned DW   = 8;
  localparam int unsigned LW   = 5;
  localparam int unsigned FH   = 4;
  localparam int          NOUT = (LW - 2) * (FH - 2);

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  logic_and_erode_if #(.DATA_WIDTH(DW)) bus ();

  logic_and_erode #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] img [FH][LW];
  logic [7:0] pat [FH][LW];
  int         mr, mc;
  logic       exp_valid, exp_fd;
  logic [7:0] exp_out;
  int         n_pass, n_chk, n_fail, n_out, n_fd;

  function automatic logic [7:0] win_and(input int cr, input int cc);
    logic [7:0] a;
    a = 8'hFF;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        a = a & img[cr + dr][cc + dc];
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sample();
    chk("data_out_valid", 32'(bus.data_out_valid), 32'(exp_valid));
    chk("data_out",       32'(bus.data_out),       32'(exp_out));
    chk("frame_done",     32'(bus.frame_done),     32'(exp_fd));
    if (bus.data_out_valid === 1'b1) n_out++;
    if (bus.frame_done === 1'b1) n_fd++;
  endtask

  // One clock: check the previous cycle's outputs, then present the next input
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clock);
    sample();
    rst_n          = 1'b1;
    bus.data_valid = v;
    bus.data_in    = d;
    exp_valid      = 1'b0;
    exp_fd         = 1'b0;
    if (v) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        exp_valid = 1'b1;
        exp_out   = win_and(mr - 1, mc - 1);
      end
      exp_fd = (mr == FH - 1) && (mc == LW - 1);
      mc++;
      if (mc == LW) begin
        mc = 0;
        mr = (mr == FH - 1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic reset_cycle(input logic v, input logic [7:0] d);
    @(negedge clock);
    sample();
    rst_n          = 1'b0;
    bus.data_valid = v;
    bus.data_in    = d;
    exp_valid      = 1'b0;
    exp_fd         = 1'b0;
    exp_out        = 8'h00;
    mr             = 0;
    mc             = 0;
  endtask

  // gap: 0 = continuous, 1 = alternate valid/idle, 2 = random idle runs
  task automatic send_pixels(input int gap, input int count);
    for (int k = 0; k < count; k++) begin
      if (gap == 2) repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom));
      drive(1'b1, pat[k / LW][k % LW]);
      if (gap == 1) drive(1'b0, 8'($urandom));
    end
  endtask

  task automatic flush();
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
  endtask

  task automatic expect_counts(input string tag, input int no, input int nf);
    chk({tag, "_outputs"}, 32'(n_out), 32'(no));
    chk({tag, "_frame_done"}, 32'(n_fd), 32'(nf));
    n_out = 0;
    n_fd  = 0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++)
        pat[r][c] = v;
  endtask

  initial begin
    n_pass = 0; n_chk = 0; n_fail = 0; n_out = 0; n_fd = 0;
    mr = 0; mc = 0;
    exp_valid = 1'b0; exp_fd = 1'b0; exp_out = 8'h00;
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    repeat (2) @(posedge clock);

    // All-ones frame, continuous
    fill(8'hFF);
    send_pixels(0, LW * FH);
    flush();
    expect_counts("all_ones", NOUT, 1);

    // Single hole at (1,1)
    fill(8'hFF);
    pat[1][1] = 8'h00;
    send_pixels(0, LW * FH);
    flush();
    expect_counts("hole", NOUT, 1);

    // Bit lanes: 0xF0 field with 0x3C at (2,3)
    fill(8'hF0);
    pat[2][3] = 8'h3C;
    send_pixels(0, LW * FH);
    flush();
    expect_counts("lanes", NOUT, 1);

    // Single hole with valid toggling
    fill(8'hFF);
    pat[1][1] = 8'h00;
    send_pixels(1, LW * FH);
    flush();
    expect_counts("gapped", NOUT, 1);

    // Back-to-back: all-zero frame then all-ones frame
    fill(8'h00);
    send_pixels(0, LW * FH);
    fill(8'hFF);
    send_pixels(0, LW * FH);
    flush();
    expect_counts("b2b", 2 * NOUT, 2);

    // Mid-frame reset landing on an accept that would complete a window
    fill(8'hFF);
    send_pixels(0, 12);
    reset_cycle(1'b1, 8'hFF);
    n_out = 0;
    n_fd  = 0;
    send_pixels(0, LW * FH);
    flush();
    expect_counts("after_reset", NOUT, 1);

    // Randomised frames: binary masks and greyscale, random gaps, some back-to-back
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < FH; r++)
        for (int c = 0; c < LW; c++)
          if (f % 2 == 0) pat[r][c] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'hFF;
          else            pat[r][c] = 8'($urandom) | 8'($urandom);
      send_pixels((f < 4) ? 2 : 0, LW * FH);
      if (f % 3 == 2) begin
        flush();
        expect_counts("random", 3 * NOUT, 3);
      end
    end
    flush();
    expect_counts("random_tail", 2 * NOUT, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
